// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
// Holds the operand width, the iteration count and the controller state type.
package mul_seq_ctrl_pkg;

  // Operand width; the datapath is built around a 32-bit adder.
  localparam int MUL_XLEN = 32;

  // One iteration per multiplier bit.
  localparam int N_ITER = 32;

  // Iteration counter width (6 bits so the count range has headroom).
  localparam int ITER_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : mul_seq_ctrl_pkg

// File: rtl/adder_32bit.sv
// 32-bit ripple-carry adder, the single arithmetic resource of the multiplier.
// Ports:
//   a_i  [31:0] in  first addend
//   b_i  [31:0] in  second addend
//   re_o [31:0] out sum (low 32 bits)
//   c_o         out carry out of bit 31
module adder_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] re_o,
  output logic        c_o
);

  logic [32:0] carry;

  assign carry[0] = 1'b0;

  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    assign re_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi+1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign c_o = carry[32];

endmodule : adder_32bit

// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 -> 64-bit unsigned shift-add multiplier with a
// valid/ready request and response handshake. One multiplier bit is
// retired per cycle, so the latency is a fixed 32 BUSY cycles.
// Ports:
//   clk_i         in   clock, rising edge
//   rst_ni        in   asynchronous active-low reset
//   req_valid_i   in   operand pair valid
//   req_ready_o   out  controller can accept operands (IDLE)
//   a_i    [31:0] in   multiplicand
//   b_i    [31:0] in   multiplier
//   resp_valid_o  out  product valid (DONE)
//   resp_ready_i  in   consumer accepts product
//   product_o [63:0] out  registered product
//   busy_o        out  operation in progress (BUSY or DONE)
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int XLEN = mul_seq_ctrl_pkg::MUL_XLEN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [2*XLEN-1:0] product_o,
  output logic              busy_o
);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);

  state_e state_q;
  state_e state_next;

  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   acc_hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [ITER_W-1:0] iter_q;
  logic [2*XLEN-1:0] product_q;

  logic [XLEN-1:0]   add_b;
  logic [XLEN-1:0]   add_sum;
  logic              add_carry;
  logic [2*XLEN-1:0] shifted;
  logic              last_iter;

  // Partial product is the multiplicand when the current multiplier bit is set.
  assign add_b = lo_q[0] ? mcand_q : '0;

  adder_32bit u_adder (
    .a_i  (acc_hi_q),
    .b_i  (add_b),
    .re_o (add_sum),
    .c_o  (add_carry)
  );

  // Carry becomes the new top bit so no product bit is lost; the retired
  // multiplier bit falls off the bottom of lo_q.
  assign shifted   = {add_carry, add_sum, lo_q[XLEN-1:1]};
  assign last_iter = (iter_q == ITER_LAST);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: if (req_valid_i)  state_next = BUSY;
      BUSY: if (last_iter)    state_next = DONE;
      DONE: if (resp_ready_i) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath. Requests outside IDLE are ignored because only the IDLE arm
  // looks at req_valid_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      lo_q      <= '0;
      iter_q    <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            mcand_q  <= a_i;
            acc_hi_q <= '0;
            lo_q     <= b_i;
            iter_q   <= '0;
          end
        end
        BUSY: begin
          {acc_hi_q, lo_q} <= shifted;
          iter_q           <= iter_q + 1'b1;
          // Product register is loaded once, so it holds outside DONE.
          if (last_iter) begin
            product_q <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign product_o    = product_q;

endmodule : mul_seq_ctrl

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: table-driven directed products plus
// hand-written sequences for backpressure, ignored requests, mid-operation
// reset and a randomised product sweep.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] product;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mul_seq_ctrl #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .a_i          (a_in),
    .b_i          (b_in),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .product_o    (product),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request from IDLE, wait for the response, hold off the
  // consumer for 'stall' cycles, then complete the handshake.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                        output logic [63:0] prod, output int lat);
    check("req_ready_before_op", 64'(req_ready), 64'd1);
    resp_ready = 1'b0;
    a_in       = a;
    b_in       = b;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      step();
      lat++;
    end
    prod = product;
    repeat (stall) step();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] prod;
    logic [63:0] golden;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          seen;

    vecs[0] = '{32'd3,          32'd5,          64'd15};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE_00000001};
    vecs[2] = '{32'd0,          32'd0,          64'd0};
    vecs[3] = '{32'd1,          32'hFFFFFFFF,   64'h00000000_FFFFFFFF};
    vecs[4] = '{32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
    vecs[5] = '{32'h80000000,   32'h80000000,   64'h40000000_00000000};
    vecs[6] = '{32'hFFFFFFFF,   32'd2,          64'h00000001_FFFFFFFE};
    vecs[7] = '{32'd6,          32'd0,          64'd0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    a_in       = '0;
    b_in       = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_product", product, 64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();
    check("reset_req_ready", 64'(req_ready), 64'd1);

    // Directed products with fixed-latency check
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, 0, prod, lat);
      $display("vec %0d: a=%h b=%h product=%h latency=%0d", i, vecs[i].a, vecs[i].b, prod, lat);
      check("vec_product", prod, vecs[i].exp);
      check("vec_latency", 64'(lat), 64'd33);
      check("vec_back_to_idle", 64'(req_ready), 64'd1);
    end

    // Zero operand with backpressure
    a_in = 32'd0; b_in = 32'h1234; req_valid = 1'b1; resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin step(); lat++; end
    check("bp_latency", 64'(lat), 64'd33);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid !== 1'b1 || product !== 64'd0 || req_ready !== 1'b0) seen++;
      step();
    end
    check("bp_hold_violations", 64'(seen), 64'd0);
    check("bp_still_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_idle_after_handshake", 64'(req_ready), 64'd1);
    check("bp_resp_valid_dropped", 64'(resp_valid), 64'd0);
    check("bp_product_held", product, 64'd0);
    $display("backpressure: a=0 b=1234 product=%h", product);

    // Request during BUSY is ignored
    a_in = 32'h10000; b_in = 32'h10000; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    repeat (4) begin step(); lat++; end
    a_in = 32'd7; b_in = 32'd7; req_valid = 1'b1;
    check("ign_req_ready_busy", 64'(req_ready), 64'd0);
    step();
    lat++;
    req_valid = 1'b0;
    while (!resp_valid && lat < 200) begin step(); lat++; end
    check("ign_latency", 64'(lat), 64'd33);
    check("ign_product", product, 64'h1_00000000);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (resp_valid || busy) seen++;
      step();
    end
    check("ign_no_second_resp", 64'(seen), 64'd0);
    $display("ignored request: product=%h", product);

    // Reset in the middle of BUSY
    a_in = 32'hABCD; b_in = 32'h1234; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (9) step();
    check("rst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_product", product, 64'd0);
    check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    check("rst_release_req_ready", 64'(req_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (resp_valid) seen++;
      step();
    end
    check("rst_no_response", 64'(seen), 64'd0);
    run_op(32'd6, 32'd7, 0, prod, lat);
    check("rst_followup_product", prod, 64'd42);
    $display("after reset: a=6 b=7 product=%h", prod);

    // Random operands with random consumer stalls; stop at first mismatch
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      golden = 64'(ra) * 64'(rb);
      run_op(ra, rb, int'($urandom_range(0, 3)), prod, lat);
      $display("rand %0d: a=%h b=%h product=%h", n, ra, rb, prod);
      check("rand_product", prod, golden);
      if (prod !== golden) break;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mul_seq_ctrl

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameters SHALL be:
- XLEN, 32, operand width; only 32 is supported, matching adder_32bit.
REQ-002 Ports SHALL be:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  operand pair valid.
- req_ready_o  out  1  controller can accept operands.
- a_i  in  32  multiplicand, unsigned.
- b_i  in  32  multiplier, unsigned.
- resp_valid_o  out  1  product valid.
- resp_ready_i  in  1  consumer accepts product.
- product_o  out  64  unsigned product a_i*b_i.
- busy_o  out  1  high in BUSY or DONE.
REQ-003 The block SHALL use one clock (clk_i) and an asynchronous active-low reset (rst_ni).

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-005 req_ready_o SHALL be high only in IDLE.
REQ-006 resp_valid_o SHALL be high only in DONE.
REQ-007 Accept: in IDLE with req_valid_i=1, the block SHALL:
- latch a_i into mcand_q;
- load acc_hi_q=0, lo_q=b_i, iter_q=0;
- go to BUSY.
REQ-008 BUSY iteration, each cycle:
- the adder SHALL be driven with a=acc_hi_q, b=(lo_q[0] ? mcand_q : 0);
- then {acc_hi_q, lo_q} <= {c_o, re_o, lo_q[31:1]};
- iter_q SHALL increment.
REQ-009 Counter: iter_q SHALL be 6 bits wide. After the iteration with iter_q=31, the FSM SHALL go to DONE with product_o={acc_hi_q, lo_q}.
REQ-010 Latency: with acceptance in cycle 0, BUSY occupies cycles 1..32 and resp_valid_o SHALL first be high in cycle 33. Latency is fixed and independent of operand values, including zero.
REQ-011 In DONE, product_o and resp_valid_o SHALL hold stable until resp_ready_i=1. On that edge the FSM SHALL return to IDLE.
REQ-012 A new request SHALL NOT be accepted in the same cycle as the response handshake. The earliest next acceptance is the cycle after returning to IDLE.
REQ-013 req_valid_i asserted in BUSY or DONE SHALL be ignored, with no effect on internal state.
REQ-014 The adder carry SHALL be captured every iteration. No product bit may be lost; full 64-bit exactness is required.
REQ-015 product_o SHALL be driven only from registers. No combinational path from any input to any output is allowed, except req_ready_o and resp_valid_o, which are pure decodes of the state register.
REQ-016 Outside DONE, product_o SHALL hold its last value.

Reset
REQ-017 On rst_ni=0, asynchronously:
- state=IDLE;
- acc_hi_q, lo_q, mcand_q, iter_q all 0;
- product_o=0, resp_valid_o=0, busy_o=0;
- req_ready_o SHALL be 1 after reset release.
REQ-018 Reset asserted mid-operation (BUSY or DONE) SHALL abandon the operation with no response ever issued. The first cycle after release SHALL be IDLE.

Structure
REQ-019 A shared package SHALL hold:
- the state enum type (IDLE, BUSY, DONE);
- the XLEN constant;
- the iteration-count constant (32).
REQ-020 The block SHALL instantiate exactly one adder_32bit sub-module as its only arithmetic resource. No other adders or multipliers are allowed.
REQ-021 Target RTL size SHALL be 120-250 lines, excluding the package.

Verification
REQ-022 Basic product: a=3, b=5, resp_ready_i=1 -> resp_valid_o first high exactly 33 cycles after acceptance; product_o=64'd15.
REQ-023 Full carry: a=b=32'hFFFFFFFF -> product_o=64'hFFFFFFFE_00000001 at cycle 33.
REQ-024 Zero operand and backpressure: a=0, b=32'h1234 with resp_ready_i=0 for 10 cycles after DONE -> resp_valid_o held, product_o=0 stable, req_ready_o=0. resp_ready_i=1 -> IDLE next cycle.
REQ-025 Ignored request: req_valid_i pulsed with a=7, b=7 during BUSY of a=32'h10000, b=32'h10000 -> product_o=64'h1_00000000; no second response.
REQ-026 Reset mid-operation: rst_ni low at cycle 10 of BUSY -> all outputs 0 immediately, req_ready_o=1 after release, no resp_valid_o. A follow-up request a=6, b=7 -> product_o=42.
REQ-027 Random check: 1000 random operand pairs with random resp_ready_i stalls -> every product_o equals the 64-bit golden a*b. The bench SHALL stop on the first mismatch.
